pulse_sync_monitor: RTL and testbench

PULSE_SYNC_MONITOR -- requirements
Module: pulse_sync_monitor

---
 rtl/pulse_sync_pkg.sv | 24 ++
 rtl/pulse_interval_counter.sv | 42 ++++
 rtl/pulse_sync_monitor.sv | 194 +++++++++++++++++++
 tb/tb_pulse_sync_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sync_pkg.sv
// ============================================================
// pulse_sync_pkg : shared FSM encoding, compare width, error codes
// Revision: 1.0
// ============================================================
`default_nettype none

package pulse_sync_pkg;

   localparam int CMP_W = 33;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_EARLY = 2'd1;
   localparam logic [1:0] ERR_LATE  = 2'd2;
   localparam logic [1:0] ERR_MISS  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pulse_interval_counter.sv
// ============================================================
// pulse_interval_counter : saturating interval counter with restart/reload
// Revision: 1.0
// ============================================================
`default_nettype none

module pulse_interval_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        restart,
   input  logic        reload,
   input  logic [31:0] reload_val,
   output logic [31:0] icnt
);

   logic [31:0] icnt_q;
   logic [31:0] icnt_d;

   always_comb begin
      icnt_d = icnt_q;
      if (restart) begin
         icnt_d = 32'd1;
      end else if (reload) begin
         icnt_d = reload_val;
      end else if (icnt_q != 32'hFFFF_FFFF) begin
         icnt_d = icnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         icnt_q <= 32'd0;
      end else begin
         icnt_q <= icnt_d;
      end
   end

   assign icnt = icnt_q;

endmodule

`default_nettype wire

// File: rtl/pulse_sync_monitor.sv
// ============================================================
// pulse_sync_monitor : periodic pulse lock monitor with flywheel output
// Revision: 1.0
// ============================================================
`default_nettype none

module pulse_sync_monitor
   import pulse_sync_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int MISS_LIMIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pulse_in,
   input  logic [31:0] CLK_PERIOD,
   input  logic [7:0]  tolerance,
   output logic        locked,
   output logic        pulse_out,
   output logic        err_early,
   output logic        err_late,
   output logic        err_miss,
   output logic [31:0] period_meas,
   output logic        period_valid
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(MISS_LIMIT + 1);

   state_t           state_q, state_d;
   logic [31:0]      p_q, p_d;
   logic [7:0]       t_q, t_d;
   logic [GW-1:0]    gcnt_q, gcnt_d;
   logic [MW-1:0]    mcnt_q, mcnt_d;
   logic             locked_q, locked_d;
   logic             pulse_out_q, pulse_out_d;
   logic             err_early_q, err_early_d;
   logic             err_late_q, err_late_d;
   logic             err_miss_q, err_miss_d;
   logic [31:0]      period_meas_q, period_meas_d;
   logic             period_valid_q, period_valid_d;

   logic [31:0]      w_icnt;
   logic             w_reload;
   logic [CMP_W-1:0] w_icnt_x, w_p_x, w_t_x, w_nom, w_lo, w_hi, w_miss_at;
   logic [1:0]       w_err_code;
   logic             w_good;
   logic [GW-1:0]    w_gnext;
   logic [MW-1:0]    w_mnext;

   pulse_interval_counter u_icnt (
      .clk        (clk),
      .reset      (reset),
      .restart    (pulse_in),
      .reload     (w_reload),
      .reload_val ({24'd0, t_q} + 32'd2),
      .icnt       (w_icnt)
   );

   // Widened to 33 bits so P+1+T and P+T+2 never wrap for any 32-bit P.
   assign w_icnt_x  = {1'b0, w_icnt};
   assign w_p_x     = {1'b0, p_q};
   assign w_t_x     = {25'd0, t_q};
   assign w_nom     = w_p_x + 33'd1;
   assign w_hi      = w_nom + w_t_x;
   assign w_lo      = (w_t_x > w_p_x) ? 33'd1 : (w_nom - w_t_x);
   assign w_miss_at = w_p_x + w_t_x + 33'd2;

   always_comb begin
      w_err_code = ERR_NONE;
      if (pulse_in) begin
         if (w_icnt_x < w_lo) begin
            w_err_code = ERR_EARLY;
         end else if (w_icnt_x > w_hi) begin
            w_err_code = ERR_LATE;
         end
      end else if (w_icnt_x == w_miss_at) begin
         w_err_code = ERR_MISS;
      end
   end

   assign w_good  = pulse_in && (w_err_code == ERR_NONE);
   assign w_gnext = gcnt_q + GW'(1);
   assign w_mnext = mcnt_q + MW'(1);

   always_comb begin
      state_d        = state_q;
      p_d            = p_q;
      t_d            = t_q;
      gcnt_d         = gcnt_q;
      mcnt_d         = mcnt_q;
      pulse_out_d    = 1'b0;
      err_early_d    = 1'b0;
      err_late_d     = 1'b0;
      err_miss_d     = 1'b0;
      period_meas_d  = period_meas_q;
      period_valid_d = 1'b0;
      w_reload       = 1'b0;

      if (pulse_in && (state_q != ST_IDLE)) begin
         period_meas_d  = w_icnt - 32'd1;
         period_valid_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            mcnt_d = '0;
            if (pulse_in) begin
               p_d     = CLK_PERIOD;
               t_d     = tolerance;
               gcnt_d  = '0;
               state_d = ST_ACQUIRE;
            end
         end
         ST_ACQUIRE: begin
            mcnt_d = '0;
            if (w_good) begin
               gcnt_d = w_gnext;
               if (w_gnext == GW'(LOCK_COUNT)) begin
                  state_d = ST_LOCKED;
               end
            end else if (pulse_in) begin
               gcnt_d = '0;
            end else if (w_err_code == ERR_MISS) begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (w_good) begin
               pulse_out_d = 1'b1;
               mcnt_d      = '0;
            end else if (w_err_code == ERR_EARLY || w_err_code == ERR_LATE) begin
               err_early_d = (w_err_code == ERR_EARLY);
               err_late_d  = (w_err_code == ERR_LATE);
               gcnt_d      = '0;
               state_d     = ST_ACQUIRE;
            end else if (w_err_code == ERR_MISS) begin
               // Flywheel: substitute a pulse and re-arm the counter one period out.
               err_miss_d  = 1'b1;
               pulse_out_d = 1'b1;
               w_reload    = 1'b1;
               mcnt_d      = w_mnext;
               if (w_mnext == MW'(MISS_LIMIT)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         p_q            <= 32'd0;
         t_q            <= 8'd0;
         gcnt_q         <= '0;
         mcnt_q         <= '0;
         locked_q       <= 1'b0;
         pulse_out_q    <= 1'b0;
         err_early_q    <= 1'b0;
         err_late_q     <= 1'b0;
         err_miss_q     <= 1'b0;
         period_meas_q  <= 32'd0;
         period_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         p_q            <= p_d;
         t_q            <= t_d;
         gcnt_q         <= gcnt_d;
         mcnt_q         <= mcnt_d;
         locked_q       <= locked_d;
         pulse_out_q    <= pulse_out_d;
         err_early_q    <= err_early_d;
         err_late_q     <= err_late_d;
         err_miss_q     <= err_miss_d;
         period_meas_q  <= period_meas_d;
         period_valid_q <= period_valid_d;
      end
   end

   assign locked       = locked_q;
   assign pulse_out    = pulse_out_q;
   assign err_early    = err_early_q;
   assign err_late     = err_late_q;
   assign err_miss     = err_miss_q;
   assign period_meas  = period_meas_q;
   assign period_valid = period_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_sync_monitor.sv
// ============================================================
// tb_pulse_sync_monitor : directed + randomized check against a cycle model
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_pulse_sync_monitor;

   localparam int     LOCK_N   = 4;
   localparam int     MISS_N   = 3;
   localparam longint ICNT_MAX = 64'h0000_0000_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pulse_in = 1'b0;
   logic [31:0] clk_period = 32'd9;
   logic [7:0]  tolerance = 8'd1;
   logic        locked, pulse_out, err_early, err_late, err_miss, period_valid;
   logic [31:0] period_meas;

   pulse_sync_monitor #(.LOCK_COUNT(LOCK_N), .MISS_LIMIT(MISS_N)) dut (
      .clk          (clk),
      .reset        (reset),
      .pulse_in     (pulse_in),
      .CLK_PERIOD   (clk_period),
      .tolerance    (tolerance),
      .locked       (locked),
      .pulse_out    (pulse_out),
      .err_early    (err_early),
      .err_late     (err_late),
      .err_miss     (err_miss),
      .period_meas  (period_meas),
      .period_valid (period_valid)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: mode 0=idle 1=acquire 2=locked; "since" = cycles since last pulse.
   int          m_mode = 0;
   longint      m_since = 0, m_p = 0, m_t = 0;
   int          m_good = 0, m_miss = 0;
   logic        e_locked = 0, e_po = 0, e_ee = 0, e_el = 0, e_em = 0, e_pv = 0;
   logic [31:0] e_pm = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      longint i, lo, hi;
      bit good, early, late, miss;
      e_po = 0; e_ee = 0; e_el = 0; e_em = 0; e_pv = 0;
      if (reset) begin
         m_mode = 0; m_since = 0; m_good = 0; m_miss = 0;
         e_pm = 0; e_locked = 0;
         return;
      end
      i     = m_since;
      lo    = (m_t > m_p) ? 1 : m_p + 1 - m_t;
      hi    = m_p + 1 + m_t;
      early = pulse_in && (i < lo);
      late  = pulse_in && (i > hi);
      good  = pulse_in && !early && !late;
      miss  = !pulse_in && (i == m_p + m_t + 2);
      m_since = pulse_in ? 1 : ((m_since < ICNT_MAX) ? m_since + 1 : m_since);
      if (pulse_in && m_mode != 0) begin
         e_pm = 32'(i - 1);
         e_pv = 1;
      end
      if (m_mode == 0) begin
         if (pulse_in) begin
            m_p = longint'(clk_period); m_t = longint'(tolerance);
            m_mode = 1; m_good = 0;
         end
      end else if (m_mode == 1) begin
         if (good) begin
            m_good++;
            if (m_good == LOCK_N) begin m_mode = 2; m_miss = 0; end
         end else if (pulse_in) m_good = 0;
         else if (miss) m_mode = 0;
      end else begin
         if (good) begin
            e_po = 1; m_miss = 0;
         end else if (pulse_in) begin
            e_ee = early; e_el = late; m_mode = 1; m_good = 0;
         end else if (miss) begin
            e_em = 1; e_po = 1; m_miss++;
            m_since = m_t + 2;
            if (m_miss == MISS_N) m_mode = 0;
         end
      end
      e_locked = (m_mode == 2);
   endtask

   task automatic step(input logic p);
      pulse_in = p;
      model_step();
      @(posedge clk);
      #1;
      check("locked", {63'd0, locked}, {63'd0, e_locked});
      check("pulse_out", {63'd0, pulse_out}, {63'd0, e_po});
      check("err_early", {63'd0, err_early}, {63'd0, e_ee});
      check("err_late", {63'd0, err_late}, {63'd0, e_el});
      check("err_miss", {63'd0, err_miss}, {63'd0, e_em});
      check("period_valid", {63'd0, period_valid}, {63'd0, e_pv});
      check("period_meas", {32'd0, period_meas}, {32'd0, e_pm});
   endtask

   task automatic gap(input int n);
      repeat (n - 1) step(1'b0);
      step(1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
   endtask

   initial begin
      int nm;
      int nom, tol, n;

      // Reset state
      do_reset();
      check("rst_locked", {63'd0, locked}, 64'd0);
      check("rst_period_meas", {32'd0, period_meas}, 64'd0);

      // Acquire and lock: P=9, T=1, interval 10
      step(1'b1);
      check("first_no_meas", {63'd0, period_valid}, 64'd0);
      repeat (3) gap(10);
      check("not_yet_locked", {63'd0, locked}, 64'd0);
      gap(10);
      check("lock_rise", {63'd0, locked}, 64'd1);
      check("meas_9", {32'd0, period_meas}, 64'd9);
      gap(10);
      check("good_pulse_out", {63'd0, pulse_out}, 64'd1);

      // Early pulse drops lock, relock after 4 good intervals
      gap(7);
      check("early_strobe", {63'd0, err_early}, 64'd1);
      check("early_unlock", {63'd0, locked}, 64'd0);
      repeat (4) gap(10);
      check("relock_after_early", {63'd0, locked}, 64'd1);

      // One omitted pulse: flywheel at 12, real pulse at 20 is good
      repeat (12) step(1'b0);
      check("miss_strobe", {63'd0, err_miss}, 64'd1);
      check("miss_flywheel", {63'd0, pulse_out}, 64'd1);
      check("miss_keeps_lock", {63'd0, locked}, 64'd1);
      repeat (7) step(1'b0);
      step(1'b1);
      check("after_miss_good", {63'd0, pulse_out}, 64'd1);

      // Three omitted pulses drop to idle
      nm = 0;
      repeat (32) begin
         step(1'b0);
         nm += int'(err_miss);
      end
      check("three_misses", 64'(nm), 64'd3);
      check("miss_unlock", {63'd0, locked}, 64'd0);

      // Late pulse at exactly P+T+2
      step(1'b1);
      repeat (4) gap(10);
      gap(12);
      check("late_strobe", {63'd0, err_late}, 64'd1);
      check("late_not_miss", {63'd0, err_miss}, 64'd0);
      check("late_no_pulse", {63'd0, pulse_out}, 64'd0);

      // Mid-lock reset, then fresh acquisition
      repeat (4) gap(10);
      check("relock_after_late", {63'd0, locked}, 64'd1);
      repeat (4) step(1'b0);
      do_reset();
      check("midlock_reset", {63'd0, locked}, 64'd0);
      step(1'b1);
      repeat (3) gap(10);
      check("reacq_pending", {63'd0, locked}, 64'd0);
      gap(10);
      check("reacq_locked", {63'd0, locked}, 64'd1);

      // Tolerance above period: lower bound clamps to 1
      do_reset();
      clk_period = 32'd2;
      tolerance  = 8'd5;
      step(1'b1);
      repeat (4) gap(1);
      check("clamp_lock", {63'd0, locked}, 64'd1);

      // Randomized intervals, parameter changes and occasional resets
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            clk_period = 32'($urandom_range(2, 20));
            tolerance  = 8'($urandom_range(0, 4));
         end
         if ($urandom_range(0, 49) == 0) do_reset();
         nom = (m_mode == 0) ? int'(clk_period) + 1 : int'(m_p) + 1;
         tol = (m_mode == 0) ? int'(tolerance) : int'(m_t);
         if ($urandom_range(0, 9) == 0) begin
            n = nom + tol + 1 + int'($urandom_range(0, 3 * (nom + tol)));
         end else begin
            n = int'($urandom_range((nom - tol - 2 < 1) ? 1 : nom - tol - 2, nom + tol + 2));
         end
         gap(n);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
